// File: rtl/arrow_spawner.sv
// arrow_spawner: frame-paced wave scheduler driving a bank of arrow slots.
// Define ARROW_SPAWNER_INVERSE_EN to enable inversed arrows at level >= 4.
module arrow_spawner #(
   parameter int unsigned NUM_SLOTS     = 4,
   parameter int unsigned WAVE_LEN      = 32,
   parameter int unsigned BASE_INTERVAL = 60,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [10:0]            hcount_in,
   input  logic [9:0]             vcount_in,
   input  logic                   start_in,
   input  logic [2:0]             level_in,
   input  logic [NUM_SLOTS-1:0]   slot_hit_in,
   output logic [NUM_SLOTS-1:0]   slot_valid_out,
   output logic [2*NUM_SLOTS-1:0] slot_direction_out,
   output logic [3*NUM_SLOTS-1:0] slot_speed_out,
   output logic [NUM_SLOTS-1:0]   slot_inversed_out,
   output logic [7:0]             spawn_count_out,
   output logic                   wave_done_out
);

   typedef enum logic [2:0] {
      C_IDLE, C_SPAWN, C_WAIT, C_DRAIN, C_DONE
   } ctrl_t;

   typedef enum logic [1:0] {
      S_FREE, S_ARMED, S_ACTIVE, S_COOL
   } slot_t;

   localparam logic [7:0] WAVE_LEN8 = 8'(WAVE_LEN);
   localparam logic [7:0] BASE8     = 8'(BASE_INTERVAL);

   ctrl_t                ctrl;
   slot_t                st [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] cool;
   logic [15:0]          lfsr;
   logic [15:0]          lfsr_next;
   logic [7:0]           frames;
   logic [7:0]           interval;
   logic [7:0]           lvl8;
   logic [7:0]           count_next;
   logic                 start_q;
   logic                 frame_tick;
   logic [NUM_SLOTS-1:0] free_vec;
   logic [NUM_SLOTS-1:0] pick;
   logic                 any_free;
   logic                 all_free;
   logic                 spawn_go;
   logic                 abort;

   assign frame_tick = (hcount_in == 11'd0) && (vcount_in == 10'd0);
   assign lfsr_next  = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
   assign lvl8       = {2'b00, level_in, 3'b000};
   assign interval   = (BASE8 < lvl8 + 8'd8) ? 8'd8 : BASE8 - lvl8;
   assign count_next = spawn_count_out + 8'd1;
   assign pick       = free_vec & (~free_vec + NUM_SLOTS'(1));
   assign any_free   = |free_vec;
   assign all_free   = &free_vec;
   assign spawn_go   = (ctrl == C_SPAWN) && start_in && any_free;
   assign abort      = !start_in &&
                       (ctrl == C_SPAWN || ctrl == C_WAIT || ctrl == C_DRAIN);

`ifdef ARROW_SPAWNER_INVERSE_EN
   logic new_inv;
   assign new_inv = lfsr[2] & (level_in >= 3'd4);
`else
   assign slot_inversed_out = '0;
`endif

   // Decode which slots are free for selection this cycle.
   always_comb begin
      free_vec = '0;
      for (int i = 0; i < NUM_SLOTS; i++)
         free_vec[i] = (st[i] == S_FREE);
   end

   // Wave controller: pacing, LFSR stepping, spawn count and done flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ctrl            <= C_IDLE;
         lfsr            <= LFSR_SEED;
         frames          <= 8'd0;
         start_q         <= 1'b0;
         spawn_count_out <= 8'd0;
         wave_done_out   <= 1'b0;
      end else begin
         start_q <= start_in;
         unique case (ctrl)
            C_IDLE: begin
               if (start_in && !start_q) begin
                  ctrl            <= C_SPAWN;
                  lfsr            <= LFSR_SEED;
                  spawn_count_out <= 8'd0;
                  wave_done_out   <= 1'b0;
               end
            end
            C_SPAWN: begin
               if (!start_in) begin
                  ctrl <= C_IDLE;
               end else if (any_free) begin
                  lfsr <= lfsr_next;
                  if (spawn_count_out < WAVE_LEN8)
                     spawn_count_out <= count_next;
                  if (count_next >= WAVE_LEN8) begin
                     ctrl <= C_DRAIN;
                  end else begin
                     ctrl   <= C_WAIT;
                     frames <= interval;
                  end
               end
            end
            C_WAIT: begin
               if (!start_in)
                  ctrl <= C_IDLE;
               else if (frames == 8'd0)
                  ctrl <= C_SPAWN;
               else if (frame_tick)
                  frames <= frames - 8'd1;
            end
            C_DRAIN: begin
               if (!start_in) begin
                  ctrl <= C_IDLE;
               end else if (all_free) begin
                  ctrl          <= C_DONE;
                  wave_done_out <= 1'b1;
               end
            end
            C_DONE: begin
               if (!start_in)
                  ctrl <= C_IDLE;
            end
            default: ctrl <= C_IDLE;
         endcase
      end
   end

   // Per-slot lifecycle with registered valid and held parameters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_SLOTS; i++)
            st[i] <= S_FREE;
         cool               <= '0;
         slot_valid_out     <= '0;
         slot_direction_out <= '0;
         slot_speed_out     <= '0;
`ifdef ARROW_SPAWNER_INVERSE_EN
         slot_inversed_out  <= '0;
`endif
      end else begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            if (abort) begin
               st[i]             <= S_COOL;
               cool[i]           <= 1'b0;
               slot_valid_out[i] <= 1'b0;
            end else begin
               unique case (st[i])
                  S_FREE: begin
                     if (spawn_go && pick[i]) begin
                        st[i]                      <= S_ARMED;
                        slot_valid_out[i]          <= 1'b1;
                        slot_direction_out[2*i+:2] <= lfsr[1:0];
                        slot_speed_out[3*i+:3]     <= level_in;
`ifdef ARROW_SPAWNER_INVERSE_EN
                        slot_inversed_out[i]       <= new_inv;
`endif
                     end
                  end
                  S_ARMED: begin
                     if (frame_tick)
                        st[i] <= S_ACTIVE;
                  end
                  S_ACTIVE: begin
                     if (slot_hit_in[i]) begin
                        st[i]             <= S_COOL;
                        cool[i]           <= 1'b0;
                        slot_valid_out[i] <= 1'b0;
                     end
                  end
                  S_COOL: begin
                     if (cool[i])
                        st[i] <= S_FREE;
                     else
                        cool[i] <= 1'b1;
                  end
                  default: st[i] <= S_FREE;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_arrow_spawner.sv
// tb_arrow_spawner: directed checks of spawn pacing, slot lifecycle,
// wave completion and abort, with frame ticks driven directly.
module tb_arrow_spawner;

`ifdef ARROW_SPAWNER_INVERSE_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        start;
   logic        start4;
   logic [2:0]  level;
   logic [3:0]  hit;
   logic [3:0]  hit4;
   logic [3:0]  valid, valid4;
   logic [7:0]  dir, dir4;
   logic [11:0] speed, speed4;
   logic [3:0]  inv, inv4;
   logic [7:0]  count, count4;
   logic        done, done4;

   int errors = 0;
   int checks = 0;

   arrow_spawner dut (
      .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
      .start_in(start), .level_in(level), .slot_hit_in(hit),
      .slot_valid_out(valid), .slot_direction_out(dir),
      .slot_speed_out(speed), .slot_inversed_out(inv),
      .spawn_count_out(count), .wave_done_out(done)
   );

   arrow_spawner #(.WAVE_LEN(4), .BASE_INTERVAL(16)) dut4 (
      .clk(clk), .rst(rst), .hcount_in(hcount), .vcount_in(vcount),
      .start_in(start4), .level_in(level), .slot_hit_in(hit4),
      .slot_valid_out(valid4), .slot_direction_out(dir4),
      .slot_speed_out(speed4), .slot_inversed_out(inv4),
      .spawn_count_out(count4), .wave_done_out(done4)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic tick;
      hcount = 11'd0;
      vcount = 10'd0;
      step();
      hcount = 11'd1;
      vcount = 10'd1;
   endtask

   task automatic test_reset;
      rst = 1'b0; start = 1'b0; start4 = 1'b0;
      level = 3'd0; hit = 4'b0; hit4 = 4'b0;
      hcount = 11'd1; vcount = 10'd1;
      repeat (3) step();
      checks++;
      if (valid !== 4'b0 || valid4 !== 4'b0) begin
         errors++;
         $display("FAIL reset_valid: got %b/%b want 0000", valid, valid4);
      end
      checks++;
      if (dir !== 8'h0 || speed !== 12'h0 || inv !== 4'h0) begin
         errors++;
         $display("FAIL reset_params: got %h %h %h want 0", dir, speed, inv);
      end
      checks++;
      if (count !== 8'd0 || done !== 1'b0 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL reset_count: got %0d %b want 0 0", count, done);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_first_spawn;
      level = 3'd0;
      start = 1'b1;
      for (int k = 0; k < 2 && valid[0] !== 1'b1; k++) step();
      checks++;
      if (valid !== 4'b0001) begin
         errors++;
         $display("FAIL first_valid: got %b want 0001", valid);
      end
      checks++;
      if (dir[1:0] !== 2'b01 || speed[2:0] !== 3'd0 || inv[0] !== 1'b0) begin
         errors++;
         $display("FAIL first_params: got %b %0d %b want 01 0 0",
                  dir[1:0], speed[2:0], inv[0]);
      end
      checks++;
      if (count !== 8'd1) begin
         errors++;
         $display("FAIL first_count: got %0d want 1", count);
      end
   endtask

   task automatic test_interval;
      logic [3:0] expv;
      for (int s = 1; s < 4; s++) begin
         expv = 4'((1 << s) - 1);
         for (int t = 0; t < 59; t++) tick();
         repeat (3) step();
         checks++;
         if (valid !== expv) begin
            errors++;
            $display("FAIL early_spawn%0d: got %b want %b", s, valid, expv);
         end
         tick();
         for (int k = 0; k < 4 && valid[s] !== 1'b1; k++) step();
         checks++;
         if (valid[s] !== 1'b1 || dir[2*s+:2] !== 2'b00 ||
             count !== 8'(s + 1)) begin
            errors++;
            $display("FAIL spawn%0d: got v=%b d=%b c=%0d want 1 00 %0d",
                     s, valid[s], dir[2*s+:2], count, s + 1);
         end
      end
      checks++;
      if (dir[1:0] !== 2'b01 || speed !== 12'h0) begin
         errors++;
         $display("FAIL hold_params: got %b %h want 01 000", dir[1:0], speed);
      end
   endtask

   task automatic test_stall_and_hit;
      for (int t = 0; t < 60; t++) tick();
      repeat (5) step();
      checks++;
      if (valid !== 4'b1111 || count !== 8'd4) begin
         errors++;
         $display("FAIL stall: got %b %0d want 1111 4", valid, count);
      end
      hit = 4'b0100;
      step();
      hit = 4'b0000;
      checks++;
      if (valid !== 4'b1011) begin
         errors++;
         $display("FAIL hit_drop: got %b want 1011", valid);
      end
      step();
      checks++;
      if (valid[2] !== 1'b0) begin
         errors++;
         $display("FAIL cool1: got %b want 0", valid[2]);
      end
      step();
      checks++;
      if (valid[2] !== 1'b0) begin
         errors++;
         $display("FAIL cool2: got %b want 0", valid[2]);
      end
      for (int k = 0; k < 4 && valid[2] !== 1'b1; k++) step();
      checks++;
      if (valid !== 4'b1111 || dir[5:4] !== 2'b10 || count !== 8'd5) begin
         errors++;
         $display("FAIL rearm: got %b %b %0d want 1111 10 5",
                  valid, dir[5:4], count);
      end
   endtask

   task automatic test_masked_hits;
      hit = 4'b0100;
      repeat (4) step();
      checks++;
      if (valid !== 4'b1111 || count !== 8'd5) begin
         errors++;
         $display("FAIL armed_mask: got %b %0d want 1111 5", valid, count);
      end
      hit = 4'b0101;
      step();
      checks++;
      if (valid !== 4'b1110) begin
         errors++;
         $display("FAIL release0: got %b want 1110", valid);
      end
      repeat (5) step();
      checks++;
      if (valid !== 4'b1110 || count !== 8'd5) begin
         errors++;
         $display("FAIL free_mask: got %b %0d want 1110 5", valid, count);
      end
      hit = 4'b0000;
   endtask

   task automatic test_level7;
      level = 3'd7;
      for (int t = 0; t < 60; t++) tick();
      for (int k = 0; k < 4 && valid[0] !== 1'b1; k++) step();
      checks++;
      if (valid[0] !== 1'b1 || dir[1:0] !== 2'b11 || speed[2:0] !== 3'd7 ||
          count !== 8'd6) begin
         errors++;
         $display("FAIL l7_spawn: got %b %b %0d %0d want 1 11 7 6",
                  valid[0], dir[1:0], speed[2:0], count);
      end
      checks++;
      if (inv[0] !== INV_EN) begin
         errors++;
         $display("FAIL l7_inv: got %b want %b", inv[0], INV_EN);
      end
      hit = 4'b0010;
      step();
      hit = 4'b0000;
      checks++;
      if (valid !== 4'b1101) begin
         errors++;
         $display("FAIL l7_release: got %b want 1101", valid);
      end
      for (int t = 0; t < 7; t++) tick();
      repeat (3) step();
      checks++;
      if (valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL l7_early: got %b want 0", valid[1]);
      end
      tick();
      for (int k = 0; k < 4 && valid[1] !== 1'b1; k++) step();
      checks++;
      if (valid[1] !== 1'b1 || dir[3:2] !== 2'b11 || speed[5:3] !== 3'd7 ||
          inv[1] !== 1'b0 || count !== 8'd7) begin
         errors++;
         $display("FAIL l7_interval: got %b %b %0d %b %0d want 1 11 7 0 7",
                  valid[1], dir[3:2], speed[5:3], inv[1], count);
      end
      checks++;
      if (speed[11:9] !== 3'd0) begin
         errors++;
         $display("FAIL l7_hold: got %0d want 0", speed[11:9]);
      end
   endtask

   task automatic test_abort;
      start = 1'b0;
      step();
      checks++;
      if (valid !== 4'b0000 || count !== 8'd7) begin
         errors++;
         $display("FAIL abort: got %b %0d want 0000 7", valid, count);
      end
      repeat (2) step();
      checks++;
      if (valid !== 4'b0000 || done !== 1'b0) begin
         errors++;
         $display("FAIL abort_hold: got %b %b want 0000 0", valid, done);
      end
      start = 1'b1;
      for (int k = 0; k < 6 && valid[0] !== 1'b1; k++) step();
      checks++;
      if (valid !== 4'b0001 || count !== 8'd1 || dir[1:0] !== 2'b01 ||
          inv[0] !== 1'b0) begin
         errors++;
         $display("FAIL restart: got %b %0d %b %b want 0001 1 01 0",
                  valid, count, dir[1:0], inv[0]);
      end
   endtask

   task automatic test_wave_done;
      start4 = 1'b1;
      for (int t = 0; t < 200 && count4 !== 8'd4; t++) tick();
      step();
      checks++;
      if (count4 !== 8'd4 || valid4 !== 4'b1111 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL w4_full: got %0d %b %b want 4 1111 0",
                  count4, valid4, done4);
      end
      tick();
      step();
      hit4 = 4'b1111;
      step();
      checks++;
      if (valid4 !== 4'b0000 || done4 !== 1'b0) begin
         errors++;
         $display("FAIL w4_hit: got %b %b want 0000 0", valid4, done4);
      end
      for (int k = 0; k < 8 && done4 !== 1'b1; k++) step();
      checks++;
      if (done4 !== 1'b1 || count4 !== 8'd4) begin
         errors++;
         $display("FAIL w4_done: got %b %0d want 1 4", done4, count4);
      end
      for (int t = 0; t < 10; t++) tick();
      checks++;
      if (valid4 !== 4'b0000 || count4 !== 8'd4 || done4 !== 1'b1) begin
         errors++;
         $display("FAIL w4_idle: got %b %0d %b want 0000 4 1",
                  valid4, count4, done4);
      end
      hit4 = 4'b0000;
      start4 = 1'b0;
      repeat (2) step();
      start4 = 1'b1;
      for (int k = 0; k < 6 && count4 !== 8'd1; k++) step();
      checks++;
      if (count4 !== 8'd1 || done4 !== 1'b0 || valid4 !== 4'b0001) begin
         errors++;
         $display("FAIL w4_restart: got %0d %b %b want 1 0 0001",
                  count4, done4, valid4);
      end
   endtask

   initial begin
      test_reset();
      test_first_spawn();
      test_interval();
      test_stall_and_hit();
      test_masked_hits();
      test_level7();
      test_abort();
      test_wave_done();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
